// File: rtl/spi_tx_sequencer_if.sv
// Handshake bundle between the SPI TX sequencer, its source FIFO and the word shifter.
// master = sequencer side, slave = FIFO/shifter/register side.
interface spi_tx_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 16
);
    logic                  start_i;
    logic [REG_WIDTH-1:0]  burst_len_i;
    logic                  fifo_empty_i;
    logic                  fifo_req_o;
    logic                  fifo_resp_i;
    logic [DATA_WIDTH-1:0] fifo_data_i;
    logic                  fifo_ack_o;
    logic                  shift_start_o;
    logic [DATA_WIDTH-1:0] shift_data_o;
    logic                  shift_done_i;
    logic                  cs_n_o;
    logic                  busy_o;
    logic                  done_o;
    logic [REG_WIDTH-1:0]  word_count_o;

    modport master (
        input  start_i, burst_len_i, fifo_empty_i, fifo_resp_i, fifo_data_i, shift_done_i,
        output fifo_req_o, fifo_ack_o, shift_start_o, shift_data_o, cs_n_o, busy_o, done_o,
               word_count_o
    );

    modport slave (
        output start_i, burst_len_i, fifo_empty_i, fifo_resp_i, fifo_data_i, shift_done_i,
        input  fifo_req_o, fifo_ack_o, shift_start_o, shift_data_o, cs_n_o, busy_o, done_o,
               word_count_o
    );
endinterface

// File: rtl/spi_tx_sequencer.sv
// SPI TX burst sequencer: pulls words from a FIFO and hands them one at a time to a shifter.
// Optional interrupt output is enabled with macro SPI_TX_SEQ_IRQ_EN.
module spi_tx_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_WIDTH  = 16,
    parameter int CS_SETUP   = 2
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic soft_rst_i,
`ifdef SPI_TX_SEQ_IRQ_EN
    input  logic irq_clr_i,
    output logic irq_o,
`endif
    spi_tx_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        FETCH     = 3'd2,
        WAIT_RESP = 3'd3,
        SHIFT     = 3'd4,
        WAIT_DONE = 3'd5,
        FINISH    = 3'd6
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [REG_WIDTH-1:0]  burst_len;
    logic [REG_WIDTH-1:0]  word_count;
    logic [REG_WIDTH-1:0]  count_inc;
    logic [7:0]            setup_cnt;
    logic                  stall;
    logic                  stall_set;
    logic                  launch;
    logic [DATA_WIDTH-1:0] shift_data;
    logic                  fifo_ack;
    logic                  fifo_req;
    logic                  shift_start;
    logic                  done;
    logic                  busy;
    logic                  cs_n;

    assign count_inc = word_count + 1'b1;
    assign launch    = bus.start_i && !bus.fifo_empty_i;
    // A bounded burst that outruns the FIFO parks in WAIT_DONE with chip select held.
    assign stall_set = (burst_len != '0) && (count_inc != burst_len) && bus.fifo_empty_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
        end else if (soft_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        fifo_req    = 1'b0;
        shift_start = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        cs_n        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                cs_n = 1'b1;
                if (launch) state_nxt = SETUP;
            end
            SETUP: begin
                if (setup_cnt <= 8'd1) state_nxt = FETCH;
            end
            FETCH: begin
                fifo_req  = 1'b1;
                state_nxt = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (bus.fifo_resp_i) state_nxt = SHIFT;
            end
            SHIFT: begin
                shift_start = 1'b1;
                state_nxt   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.shift_done_i) begin
                    if ((burst_len != '0) && (count_inc == burst_len)) state_nxt = FINISH;
                    else if (bus.fifo_empty_i) state_nxt = (burst_len == '0) ? FINISH : WAIT_DONE;
                    else state_nxt = FETCH;
                end else if (stall && !bus.fifo_empty_i) begin
                    state_nxt = FETCH;
                end
            end
            FINISH: begin
                done      = 1'b1;
                cs_n      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                cs_n      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            burst_len  <= '0;
            word_count <= '0;
            setup_cnt  <= '0;
            stall      <= 1'b0;
            shift_data <= '0;
            fifo_ack   <= 1'b0;
        end else if (soft_rst_i) begin
            // Soft reset also suppresses a pending ack; the FIFO clears its own handshake.
            burst_len  <= '0;
            word_count <= '0;
            setup_cnt  <= '0;
            stall      <= 1'b0;
            shift_data <= '0;
            fifo_ack   <= 1'b0;
        end else begin
            fifo_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        burst_len  <= bus.burst_len_i;
                        word_count <= '0;
                        setup_cnt  <= 8'(CS_SETUP);
                        stall      <= 1'b0;
                    end
                end
                SETUP: begin
                    if (setup_cnt != 8'd0) setup_cnt <= setup_cnt - 8'd1;
                end
                WAIT_RESP: begin
                    if (bus.fifo_resp_i) begin
                        shift_data <= bus.fifo_data_i;
                        fifo_ack   <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.shift_done_i) begin
                        word_count <= count_inc;
                        stall      <= stall_set;
                    end else if (stall && !bus.fifo_empty_i) begin
                        stall <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.fifo_req_o    = fifo_req;
    assign bus.fifo_ack_o    = fifo_ack;
    assign bus.shift_start_o = shift_start;
    assign bus.shift_data_o  = shift_data;
    assign bus.cs_n_o        = cs_n;
    assign bus.busy_o        = busy;
    assign bus.done_o        = done;
    assign bus.word_count_o  = word_count;

`ifdef SPI_TX_SEQ_IRQ_EN
    logic irq;

    // Clear has priority over a same-cycle completion.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            irq <= 1'b0;
        end else if (soft_rst_i || irq_clr_i) begin
            irq <= 1'b0;
        end else if (done) begin
            irq <= 1'b1;
        end
    end

    assign irq_o = irq;
`endif

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed bench for spi_tx_sequencer with FIFO/shifter responders and a transaction-level scoreboard.
module tb_spi_tx_sequencer;
    localparam int DW  = 16;
    localparam int RW  = 16;
    localparam int CSS = 2;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    logic soft_rst = 1'b0;
`ifdef SPI_TX_SEQ_IRQ_EN
    logic irq_clr = 1'b0;
    logic irq;
    logic irq_m = 1'b0;
`endif

    spi_tx_sequencer_if #(.DATA_WIDTH(DW), .REG_WIDTH(RW)) bus ();

    spi_tx_sequencer #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .CS_SETUP(CSS)) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .soft_rst_i (soft_rst),
`ifdef SPI_TX_SEQ_IRQ_EN
        .irq_clr_i  (irq_clr),
        .irq_o      (irq),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int exp_wc = 0;
    int done_cnt = 0;
    int sent_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic start_burst(input logic [RW-1:0] len);
        bus.start_i     = 1'b1;
        bus.burst_len_i = len;
        cyc(1);
        bus.start_i     = 1'b0;
        bus.burst_len_i = '0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            cyc(1);
            if (!bus.busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: busy still high after %0d cycles, want idle", name, limit);
        end
    endtask

    task automatic wait_shift(input string name, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            cyc(1);
            if (bus.shift_start_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no shift_start within %0d cycles, want one", name, limit);
        end
    endtask

    // FIFO responder: response one cycle after the request, pop on ack, response held one extra cycle.
    initial begin
        bit req_seen = 1'b0;
        bit pop_pending = 1'b0;
        bit drop_resp = 1'b0;
        bus.fifo_resp_i  = 1'b0;
        bus.fifo_data_i  = '0;
        bus.fifo_empty_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!arst_n || soft_rst) begin
                req_seen = 1'b0;
                pop_pending = 1'b0;
                drop_resp = 1'b0;
                bus.fifo_resp_i = 1'b0;
            end else begin
                if (drop_resp) begin
                    bus.fifo_resp_i = 1'b0;
                    drop_resp = 1'b0;
                end
                if (pop_pending) begin
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                    pop_pending = 1'b0;
                    drop_resp = 1'b1;
                end
                if (bus.fifo_ack_o) pop_pending = 1'b1;
                if (bus.fifo_req_o) begin
                    req_seen = 1'b1;
                end else if (req_seen && fifo_q.size() > 0) begin
                    bus.fifo_resp_i = 1'b1;
                    bus.fifo_data_i = fifo_q[0];
                    req_seen = 1'b0;
                end
            end
            bus.fifo_empty_i = (fifo_q.size() == 0);
        end
    end

    // Shifter responder: done pulse 8 cycles after each start.
    initial begin
        int sh_cnt = 0;
        bus.shift_done_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.shift_done_i = 1'b0;
            if (!arst_n || soft_rst) begin
                sh_cnt = 0;
            end else begin
                if (sh_cnt > 0) begin
                    sh_cnt--;
                    if (sh_cnt == 0) bus.shift_done_i = 1'b1;
                end
                if (bus.shift_start_o) sh_cnt = 8;
            end
        end
    end

    // Scoreboard: words leave in push order, chip select low exactly while a burst is active
    // (busy and not yet finishing), and each completion reports the expected word count.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        check("cs_n_vs_activity", bus.cs_n_o, !(bus.busy_o && !bus.done_o));
        if (bus.shift_start_o) begin
            sent_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_shift_word: got %0h want no word", bus.shift_data_o);
            end else begin
                w = exp_q.pop_front();
                check("shift_data_order", bus.shift_data_o, w);
            end
        end
        if (bus.done_o) begin
            done_cnt++;
            check("word_count_at_done", bus.word_count_o, exp_wc);
            check("words_sent_at_done", sent_cnt, exp_wc);
        end
`ifdef SPI_TX_SEQ_IRQ_EN
        if (!arst_n) irq_m = 1'b0;
        check("irq_model", irq, irq_m);
        if (!arst_n || soft_rst || irq_clr) irq_m = 1'b0;
        else if (bus.done_o) irq_m = 1'b1;
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i     = 1'b0;
        bus.burst_len_i = '0;
        #2;
        check("rst_cs_n", bus.cs_n_o, 1);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_word_count", bus.word_count_o, 0);
        check("rst_fifo_req", bus.fifo_req_o, 0);
        check("rst_fifo_ack", bus.fifo_ack_o, 0);
        check("rst_shift_start", bus.shift_start_o, 0);
        check("rst_shift_data", bus.shift_data_o, 0);
        cyc(3);
        arst_n = 1'b1;
        cyc(2);

        // Bounded burst of three words
        push(16'h00A1); push(16'h00B2); push(16'h00C3);
        exp_wc = 3; sent_cnt = 0; done_cnt = 0;
        cyc(2);
        start_burst(16'd3);
        check("cs_low_after_start", bus.cs_n_o, 0);
        check("busy_after_start", bus.busy_o, 1);
        wait_idle("burst3_complete", 200);
        check("burst3_done_once", done_cnt, 1);
        check("burst3_word_count", bus.word_count_o, 3);
        check("burst3_cs_released", bus.cs_n_o, 1);
        check("burst3_all_sent", exp_q.size(), 0);

        // Start with an empty FIFO is ignored
        start_burst(16'd5);
        check("empty_start_busy", bus.busy_o, 0);
        check("empty_start_cs", bus.cs_n_o, 1);
        check("empty_start_count_kept", bus.word_count_o, 3);
        cyc(3);
        check("empty_start_still_idle", bus.busy_o, 0);

        // Unbounded burst drains the FIFO
        push(16'h1111); push(16'h2222);
        exp_wc = 2; sent_cnt = 0; done_cnt = 0;
        cyc(2);
        start_burst(16'd0);
        wait_idle("burst0_complete", 200);
        check("burst0_done_once", done_cnt, 1);
        check("burst0_word_count", bus.word_count_o, 2);

        // Bounded burst outrunning the FIFO stalls, then resumes
        push(16'h3A3A); push(16'h4B4B);
        exp_wc = 4; sent_cnt = 0; done_cnt = 0;
        cyc(2);
        start_burst(16'd4);
        cyc(50);
        check("stall_busy", bus.busy_o, 1);
        check("stall_cs_low", bus.cs_n_o, 0);
        check("stall_sent", sent_cnt, 2);
        check("stall_word_count", bus.word_count_o, 2);
        start_burst(16'd1);
        check("busy_start_ignored", bus.busy_o, 1);
        push(16'h5C5C); push(16'h6D6D);
        wait_idle("stall_complete", 300);
        check("stall_done_once", done_cnt, 1);
        check("stall_word_count_final", bus.word_count_o, 4);

        // Async reset in WAIT_DONE of the second word
        push(16'h7001); push(16'h7002); push(16'h7003);
        exp_wc = 3; sent_cnt = 0; done_cnt = 0;
        cyc(2);
        start_burst(16'd3);
        wait_shift("arst_first_word", 100);
        wait_shift("arst_second_word", 100);
        cyc(3);
        check("arst_pre_count", bus.word_count_o, 1);
        arst_n = 1'b0;
        #1;
        check("arst_cs_n", bus.cs_n_o, 1);
        check("arst_busy", bus.busy_o, 0);
        check("arst_word_count", bus.word_count_o, 0);
        check("arst_shift_data", bus.shift_data_o, 0);
        fifo_q.delete();
        exp_q.delete();
        cyc(2);
        arst_n = 1'b1;
        cyc(2);
        check("arst_no_done", done_cnt, 0);

        // Soft reset wins over start, and soft reset in SETUP aborts
        push(16'h8001); push(16'h8002); push(16'h8003);
        exp_wc = 3; sent_cnt = 0; done_cnt = 0;
        cyc(2);
        soft_rst = 1'b1;
        start_burst(16'd3);
        soft_rst = 1'b0;
        check("soft_over_start_busy", bus.busy_o, 0);
        start_burst(16'd3);
        check("setup_entered", bus.busy_o, 1);
        soft_rst = 1'b1;
        cyc(1);
        soft_rst = 1'b0;
        check("soft_cs_n", bus.cs_n_o, 1);
        check("soft_busy", bus.busy_o, 0);
        check("soft_word_count", bus.word_count_o, 0);
        cyc(2);
        check("soft_no_done", done_cnt, 0);
        start_burst(16'd3);
        wait_idle("post_reset_burst", 200);
        check("post_reset_done_once", done_cnt, 1);
        check("post_reset_word_count", bus.word_count_o, 3);

`ifdef SPI_TX_SEQ_IRQ_EN
        check("irq_set_after_burst", irq, 1);
        irq_clr = 1'b1;
        cyc(1);
        check("irq_cleared", irq, 0);
        push(16'h9001);
        exp_wc = 1; sent_cnt = 0; done_cnt = 0;
        cyc(2);
        start_burst(16'd1);
        wait_idle("irq_burst", 200);
        cyc(1);
        check("irq_clear_wins", irq, 0);
        irq_clr = 1'b0;
`endif

        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
